// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
package sccb_pkg;

  localparam logic [15:0] SCCB_END       = 16'hFFFF;
  localparam logic [15:0] SCCB_DELAY     = 16'hFFF0;
  localparam int          BITS_PER_WRITE = 27;

  typedef enum logic [2:0] {
    IDLE, FETCH, START, BIT, STOP, GAP, DELAY, DONE
  } sccb_state_t;

  typedef logic [15:0] rom_table_t [256];

  // Minimal power-up table: soft reset, settle, then RGB output with default scaling.
  localparam rom_table_t DEFAULT_TABLE = '{
    0: 16'h1280,
    1: SCCB_DELAY,
    2: 16'h1204,
    3: 16'h1100,
    4: 16'h0C00,
    5: 16'h3E00,
    default: SCCB_END
  };

  // The ninth bit of each byte is the slave's don't-care slot.
  function automatic logic is_ack_bit(input logic [4:0] bit_idx);
    return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// 256 x 16 synchronous register-table ROM; one cycle from address to data.
module ov7670_reg_rom
  import sccb_pkg::*;
#(
  parameter rom_table_t TABLE = DEFAULT_TABLE
) (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [15:0] data
);

  always_ff @(posedge clk) begin
    data <= TABLE[addr];
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the OV7670 register table and issues one three-phase SCCB write per
// entry, honouring delay and end-of-table markers.
module sccb_config_sequencer
  import sccb_pkg::*;
#(
  parameter int         QTR_CYCLES   = 63,
  parameter int         DELAY_CYCLES = 250000,
  parameter logic [7:0] DEVICE_ID    = 8'h42,
  parameter rom_table_t ROM_TABLE    = DEFAULT_TABLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       sioc,
  output logic       siod,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic [7:0] reg_index
);

  localparam int            QW         = $clog2(QTR_CYCLES);
  localparam int            DW         = $clog2(DELAY_CYCLES + 1);
  localparam logic [QW-1:0] QTR_LAST   = QW'(QTR_CYCLES - 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT   = 5'(BITS_PER_WRITE - 1);

  sccb_state_t   state, state_nx;
  logic [QW-1:0] qcnt, qcnt_nx;
  logic [1:0]    phase, phase_nx;
  logic [4:0]    bit_cnt, bit_nx;
  logic [23:0]   shreg, sh_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [7:0]    idx_nx;
  logic          fetch_wait, fetch_nx;
  logic          start_q, start_d;
  logic [15:0]   rom_data;
  logic          start_rise, qtr_end, ack_bit, advance;

  ov7670_reg_rom #(.TABLE(ROM_TABLE)) u_rom (
    .clk  (clk),
    .addr (reg_index),
    .data (rom_data)
  );

  assign start_rise = start_q & ~start_d;
  assign qtr_end    = (qcnt == QTR_LAST);
  assign ack_bit    = is_ack_bit(bit_cnt);
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      qcnt       <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      dcnt       <= '0;
      reg_index  <= '0;
      fetch_wait <= 1'b0;
      start_q    <= 1'b0;
      start_d    <= 1'b0;
    end else begin
      state      <= state_nx;
      qcnt       <= qcnt_nx;
      phase      <= phase_nx;
      bit_cnt    <= bit_nx;
      shreg      <= sh_nx;
      dcnt       <= dcnt_nx;
      reg_index  <= idx_nx;
      fetch_wait <= fetch_nx;
      start_q    <= start;
      start_d    <= start_q;
    end
  end

  always_comb begin
    state_nx = state;
    qcnt_nx  = qcnt;
    phase_nx = phase;
    bit_nx   = bit_cnt;
    sh_nx    = shreg;
    dcnt_nx  = dcnt;
    idx_nx   = reg_index;
    fetch_nx = fetch_wait;
    advance  = 1'b0;
    sioc     = 1'b1;
    siod     = 1'b1;
    siod_oe  = 1'b1;

    if (state inside {START, BIT, STOP, GAP}) begin
      qcnt_nx = qtr_end ? '0 : qcnt + 1'b1;
    end

    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          state_nx = FETCH;
          idx_nx   = '0;
          fetch_nx = 1'b0;
        end
      end
      // First cycle lets the ROM register the entry; second cycle decodes it.
      FETCH: begin
        fetch_nx = 1'b1;
        if (fetch_wait) begin
          fetch_nx = 1'b0;
          if (rom_data == SCCB_END) begin
            state_nx = DONE;
          end else if (rom_data == SCCB_DELAY) begin
            state_nx = DELAY;
            dcnt_nx  = '0;
          end else begin
            state_nx = START;
            sh_nx    = {DEVICE_ID, rom_data};
            qcnt_nx  = '0;
            phase_nx = '0;
            bit_nx   = '0;
          end
        end
      end
      START: begin
        siod = 1'b0;
        sioc = (phase == 2'd0);
        if (qtr_end) begin
          phase_nx = (phase == 2'd1) ? 2'd0 : phase + 1'b1;
          if (phase == 2'd1) state_nx = BIT;
        end
      end
      BIT: begin
        sioc    = phase[1];
        siod_oe = ~ack_bit;
        siod    = ack_bit ? 1'b1 : shreg[23];
        if (qtr_end) begin
          phase_nx = phase + 1'b1;
          if (phase == 2'd3) begin
            if (!ack_bit) sh_nx = {shreg[22:0], 1'b0};
            if (bit_cnt == LAST_BIT) state_nx = STOP;
            else bit_nx = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        sioc = (phase != 2'd0);
        siod = (phase == 2'd2);
        if (qtr_end) begin
          phase_nx = (phase == 2'd2) ? 2'd0 : phase + 1'b1;
          if (phase == 2'd2) state_nx = GAP;
        end
      end
      GAP: begin
        if (qtr_end) begin
          phase_nx = phase + 1'b1;
          advance  = (phase == 2'd3);
        end
      end
      DELAY: begin
        dcnt_nx = dcnt + 1'b1;
        advance = (dcnt == DELAY_LAST);
      end
      default: ;
    endcase

    // The last table slot finishes the run instead of wrapping the index.
    if (advance) begin
      if (reg_index == 8'hFF) begin
        state_nx = DONE;
      end else begin
        state_nx = FETCH;
        idx_nx   = reg_index + 1'b1;
        fetch_nx = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for the SCCB sequencer: three instances with different register
// tables, decoding the bus at the pins and checking timing against hand-derived values.
module tb_sccb_config_sequencer;
  import sccb_pkg::*;

  localparam rom_table_t TABLE_A = '{0: 16'h1280, default: SCCB_END};
  localparam rom_table_t TABLE_B = '{0: 16'h1280, 1: SCCB_DELAY, 2: 16'h1100, default: SCCB_END};
  localparam rom_table_t TABLE_C = '{default: 16'h1280};
  localparam logic [26:0] OE_MASK = 27'b111111110_111111110_111111110;

  logic       clk = 1'b0;
  logic       reset_drv [3];
  logic       start_drv [3];
  logic       sioc_o [3];
  logic       siod_o [3];
  logic       oe_o [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic [7:0] idx_o [3];

  int          checks = 0;
  int          errors = 0;
  int          sel;
  int          done_k, rises, start_conds, first_start_k, second_start_k, first_stop_k;
  int          busy_gaps, idx_cnt, falls;
  int          idx_seq [8];
  logic        busy_at_done, prev_sioc;
  logic [26:0] rx0, rx1, oe0, oe1;

  always #5 clk = ~clk;

  sccb_config_sequencer #(.QTR_CYCLES(4), .DELAY_CYCLES(100), .DEVICE_ID(8'h42),
                          .ROM_TABLE(TABLE_A)) dut_a (
    .clk(clk), .reset(reset_drv[0]), .start(start_drv[0]), .sioc(sioc_o[0]),
    .siod(siod_o[0]), .siod_oe(oe_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .reg_index(idx_o[0])
  );

  sccb_config_sequencer #(.QTR_CYCLES(4), .DELAY_CYCLES(100), .DEVICE_ID(8'h42),
                          .ROM_TABLE(TABLE_B)) dut_b (
    .clk(clk), .reset(reset_drv[1]), .start(start_drv[1]), .sioc(sioc_o[1]),
    .siod(siod_o[1]), .siod_oe(oe_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .reg_index(idx_o[1])
  );

  sccb_config_sequencer #(.QTR_CYCLES(2), .DELAY_CYCLES(100), .DEVICE_ID(8'h42),
                          .ROM_TABLE(TABLE_C)) dut_c (
    .clk(clk), .reset(reset_drv[2]), .start(start_drv[2]), .sioc(sioc_o[2]),
    .siod(siod_o[2]), .siod_oe(oe_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .reg_index(idx_o[2])
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start on the selected instance, then samples once per cycle at the
  // falling edge (k = posedges since start was first sampled) until done or max_k.
  task automatic apply_stimulus(input int max_k, input int p1, input int p2);
    logic       ps, pd;
    logic [7:0] last_idx;
    done_k = -1; rises = 0; start_conds = 0; busy_gaps = 0; idx_cnt = 0;
    first_start_k = -1; second_start_k = -1; first_stop_k = -1;
    rx0 = '0; rx1 = '0; oe0 = '0; oe1 = '0; busy_at_done = 1'bx;
    last_idx = '0;
    ps = sioc_o[sel];
    pd = siod_o[sel];
    start_drv[sel] = 1'b1;
    for (int k = 0; k <= max_k && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) start_drv[sel] = 1'b0;
      if (k == p1 || k == p2) start_drv[sel] = 1'b1;
      if (k == p1 + 2 || k == p2 + 2) start_drv[sel] = 1'b0;
      if (sioc_o[sel] && !ps) begin
        if (rises < 27) begin
          rx0 = {rx0[25:0], siod_o[sel]};
          oe0 = {oe0[25:0], oe_o[sel]};
        end else if (rises >= 28 && rises < 55) begin
          rx1 = {rx1[25:0], siod_o[sel]};
          oe1 = {oe1[25:0], oe_o[sel]};
        end
        rises++;
      end
      if (sioc_o[sel] && ps && siod_o[sel] && !pd && first_stop_k < 0) first_stop_k = k;
      if (sioc_o[sel] && ps && !siod_o[sel] && pd) begin
        start_conds++;
        if (start_conds == 1) first_start_k = k;
        if (start_conds == 2) second_start_k = k;
      end
      if (k >= 1 && (idx_cnt == 0 || idx_o[sel] != last_idx)) begin
        if (idx_cnt < 8) idx_seq[idx_cnt] = int'(idx_o[sel]);
        idx_cnt++;
        last_idx = idx_o[sel];
      end
      if (k >= 1 && !busy_o[sel] && !done_o[sel]) busy_gaps++;
      if (k >= 1 && done_o[sel]) begin
        done_k = k;
        busy_at_done = busy_o[sel];
      end
      ps = sioc_o[sel];
      pd = siod_o[sel];
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset_drv[i] = 1'b1;
      start_drv[i] = 1'b0;
    end
    sel = 0;
    repeat (3) @(negedge clk);
    check_output("reset_sioc", sioc_o[0], 1);
    check_output("reset_siod", siod_o[0], 1);
    check_output("reset_oe", oe_o[0], 1);
    check_output("reset_busy", busy_o[0], 0);
    check_output("reset_done", done_o[0], 0);
    check_output("reset_idx", idx_o[0], 0);

    for (int i = 0; i < 3; i++) reset_drv[i] = 1'b0;
    falls = 0;
    prev_sioc = sioc_o[0];
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!sioc_o[0] && prev_sioc) falls++;
      prev_sioc = sioc_o[0];
    end
    check_output("idle_sioc_falls", falls, 0);
    check_output("idle_busy", busy_o[0], 0);
    check_output("idle_done", done_o[0], 0);

    // Table {0x1280, END}: 2 fetch + 117 quarters of 4 + end fetch + 1 sync cycle.
    $display("[TB] table A: single write");
    sel = 0;
    apply_stimulus(600, -1, -1);
    check_output("a_done_cycle", done_k, 473);
    check_output("a_busy_at_done", busy_at_done, 0);
    check_output("a_busy_gaps", busy_gaps, 0);
    check_output("a_first_start", first_start_k, 3);
    check_output("a_sioc_rises", rises, 28);
    check_output("a_bytes", {rx0[26:19], rx0[17:10], rx0[8:1]}, 24'h421280);
    check_output("a_oe_mask", oe0, OE_MASK);
    check_output("a_idx_final", idx_o[0], 1);

    // Table {0x1280, DELAY, 0x1100, END}, with start pulses in BIT (k=100) and DELAY (k=500).
    $display("[TB] table B: write, delay, write");
    sel = 1;
    apply_stimulus(1500, 100, 500);
    check_output("b_done_cycle", done_k, 1045);
    check_output("b_busy_gaps", busy_gaps, 0);
    check_output("b_first_stop", first_stop_k, 451);
    check_output("b_stop_to_start", second_start_k - first_stop_k, 4 + 120);
    check_output("b_idx_count", idx_cnt, 4);
    check_output("b_idx_seq", {idx_seq[0][7:0], idx_seq[1][7:0], idx_seq[2][7:0], idx_seq[3][7:0]},
                 32'h00010203);
    check_output("b_bytes1", {rx0[26:19], rx0[17:10], rx0[8:1]}, 24'h421280);
    check_output("b_bytes2", {rx1[26:19], rx1[17:10], rx1[8:1]}, 24'h421100);
    check_output("b_oe_mask2", oe1, OE_MASK);

    // Restart from DONE, then reset during bit 11 (second byte, Q0 with sioc low).
    $display("[TB] table B: restart and mid-byte reset");
    apply_stimulus(190, -1, -1);
    check_output("b_restart_done_clr", done_o[1], 0);
    check_output("b_restart_busy", busy_o[1], 1);
    check_output("b_restart_idx", idx_seq[0], 0);
    check_output("b_mid_rises", rises, 11);
    check_output("b_mid_sioc", sioc_o[1], 0);
    reset_drv[1] = 1'b1;
    @(negedge clk);
    check_output("b_rst_sioc", sioc_o[1], 1);
    check_output("b_rst_siod", siod_o[1], 1);
    check_output("b_rst_oe", oe_o[1], 1);
    check_output("b_rst_busy", busy_o[1], 0);
    check_output("b_rst_done", done_o[1], 0);
    check_output("b_rst_idx", idx_o[1], 0);
    reset_drv[1] = 1'b0;
    repeat (4) @(negedge clk);
    apply_stimulus(1500, -1, -1);
    check_output("b_rerun_done", done_k, 1045);
    check_output("b_rerun_bytes", {rx0[26:19], rx0[17:10], rx0[8:1]}, 24'h421280);
    check_output("b_rerun_idx", idx_o[1], 3);

    // 256 writes with no END marker, QTR_CYCLES=2: 256 * (2 + 117*2) + 1.
    $display("[TB] table C: 256 writes without end marker");
    sel = 2;
    apply_stimulus(70000, -1, -1);
    check_output("c_done_cycle", done_k, 60417);
    check_output("c_start_conds", start_conds, 256);
    check_output("c_sioc_rises", rises, 256 * 28);
    check_output("c_idx_count", idx_cnt, 256);
    check_output("c_idx_final", idx_o[2], 255);
    check_output("c_bytes", {rx0[26:19], rx0[17:10], rx0[8:1]}, 24'h421280);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_config_sequencer.md
# sccb_config_sequencer

Sequences the OV7670 camera's power-up register configuration over the SCCB (I2C-like) two-wire bus. On a start request it walks a register table of {register address, value} entries and issues one three-phase SCCB write per entry. Table entries can also request a timed delay or mark the end of the table. It sits in the camera top level on the 25 MHz system clock, drives the camera's SIOC and SIOD PMOD pins, and reports busy/done to the rest of the design.

## Interface
Parameters:
- QTR_CYCLES, 63: clk cycles per SCCB quarter-bit; SIOC period = 4*QTR_CYCLES (about 99 kHz at 25 MHz).
- DELAY_CYCLES, 250000: wait length for a delay entry (10 ms at 25 MHz).
- DEVICE_ID, 8'h42: SCCB write ID byte.

Ports:
- clk  in  1  system clock (25 MHz); the only clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; only its rising edge is used (registered internally).
- sioc  out  1  SCCB clock.
- siod  out  1  SCCB data value.
- siod_oe  out  1  1 = drive siod; 0 = release (board pull-up).
- busy  out  1  high from accepted start until DONE.
- done  out  1  level; high once the table completes; cleared by the next accepted start.
- reg_index  out  8  table index currently being processed.

## Operation
- Reset values: sioc=1, siod=1, siod_oe=1, busy=0, done=0, reg_index=0, state=IDLE.
- State machine states: IDLE, FETCH, START, BIT, STOP, GAP, DELAY, DONE.
- IDLE/DONE + start rising edge -> FETCH. Set reg_index=0, busy=1, done=0.
- A start edge in any other state is ignored.
- FETCH: 2 cycles (synchronous ROM read, 1-cycle latency, plus decode). Decode the 16-bit entry:
  - 16'hFFFF: go to DONE.
  - 16'hFFF0: go to DELAY.
  - otherwise: load the shift register with {DEVICE_ID, entry[15:8], entry[7:0]} and go to START.
- START phases (QTR each): S0 siod=0 with sioc=1; S1 sioc=0.
- BIT: 27 bits, 3 bytes of 9 bits, MSB first. Each bit has four quarters:
  - Q0: sioc=0, set siod.
  - Q1: sioc=0.
  - Q2: sioc=1.
  - Q3: sioc=1.
  - The 9th bit of each byte is don't-care: siod_oe=0 for the whole bit. siod_oe=1 otherwise.
- STOP phases (QTR each): P0 sioc=0, siod=0; P1 sioc=1, siod=0; P2 siod=1.
- GAP: 4*QTR idle with sioc=1, siod=1. Then increment reg_index and go to FETCH.
- DELAY: wait DELAY_CYCLES with the bus idle, then increment reg_index and go to FETCH.
- Index 255 with no end marker: process that entry, then go to DONE. reg_index never wraps.
- DONE: busy=0, done=1, bus idle. Stay until the next start edge.
- Reset mid-operation: every output returns to its reset value on the next clock edge, even mid-byte. The camera resynchronises on the next START condition.

## Timing
- Per write entry: 2 (FETCH) + 117*QTR_CYCLES cycles. The 117 quarters are START 2 + BIT 108 + STOP 3 + GAP 4.
- Per delay entry: 2 + DELAY_CYCLES cycles.
- Start edge detection: start is registered, so the FSM leaves IDLE 1 cycle after start is first seen high.
- Table {write, end}: done rises 117*QTR_CYCLES + 5 cycles after start is first sampled high.
- siod only changes while sioc=0, except during S0 and P2.
- Counter widths:
  - quarter counter: $clog2(QTR_CYCLES)
  - delay counter: $clog2(DELAY_CYCLES+1)
  - bit counter: 5 bits (0..26)

## Structure
- Shared package `sccb_pkg`:
  - SCCB_END = 16'hFFFF, SCCB_DELAY = 16'hFFF0.
  - State enum.
  - BITS_PER_WRITE = 27.
- Sub-module `ov7670_reg_rom`: 256 x 16 synchronous ROM (addr 8 in, data 16 out, 1-cycle latency) holding the camera register table. The bench supplies its own contents.
- The rest is one FSM with a quarter counter, bit counter, shift register and delay counter. Expected size is about 200 lines.

## Test plan
Directed scenarios, with QTR_CYCLES=4 and DELAY_CYCLES=100 unless stated:
- Reset held, then released: sioc=1, siod=1, siod_oe=1, busy=0, done=0; no sioc edge for 1000 cycles.
- Table {16'h1280, END}, one start pulse:
  - the bench decodes bytes 0x42, 0x12, 0x80 on sioc rising edges;
  - siod_oe=0 exactly during bits 9, 18, 27;
  - done rises at cycle 117*4+5 = 473; busy falls in the same cycle.
- Table {16'h1280, DELAY, 16'h1100, END}: the STOP of the first write and the START of the second are separated by 4*4 + 2 + 100 + 2 = 120 cycles; reg_index steps 0, 1, 2, 3.
- Start pulses during BIT and during DELAY: ignored, no restart. A start in DONE clears done and re-runs from reg_index=0.
- Reset asserted in the middle of the second byte: next cycle sioc=1, siod=1, busy=0. A later start produces the full sequence from index 0.
- Table of 256 write entries with no END: all 256 writes are issued, then DONE; reg_index holds 255.
